// File: rtl/mc_control_unit.sv
// Multi-cycle RV32I control unit: instruction register plus FETCH/DECODE/EXEC/MEM/WB sequencer.
// Latency (zero-wait memories): branch 3, ALU/LUI/AUIPC/JAL/JALR 4, store 4, load 5 cycles; +1 per ack-wait cycle.
// Backpressure: req held until ack (stale acks ignored); optional timeout pulses o_bus_err and halts.
//
// Optional feature macro: MC_CTRL_RV32M_EN
//   When defined, OP/funct7=0000001 (RV32M) is legal and the multiply/divide handshake
//   ports o_md_start, o_md_op and i_md_done are present.
//
// Ports:
//   i_clk, i_rst_n                 clock, asynchronous active-low reset
//   i_imem_rdata, i_imem_ack       instruction fetch data / completion
//   i_dmem_ack                     data access completion
//   i_br_less, i_br_equal          branch comparator results
//   o_imem_req, o_dmem_req         memory requests; o_mem_wren qualifies a store
//   o_instr                        instruction register
//   o_pc_wren, o_pc_sel            PC update strobe and source (0 = PC+4, 1 = ALU)
//   o_rd_wren, o_wb_sel            register-file write strobe and source
//   o_opa_sel, o_opb_sel           ALU operand selects
//   o_br_un, o_jalr_mode, o_alu_op compare mode, JALR flag, ALU operation
//   o_insn_vld, o_illegal          retire pulse, illegal-instruction pulse
//   o_bus_err, o_halted            timeout pulse, halted status
module mc_control_unit #(
    parameter int TIMEOUT_CYC  = 255,
    parameter bit ILLEGAL_HALT = 1'b1
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [31:0] i_imem_rdata,
    input  logic        i_imem_ack,
    input  logic        i_dmem_ack,
    input  logic        i_br_less,
    input  logic        i_br_equal,
    output logic        o_imem_req,
    output logic        o_dmem_req,
    output logic        o_mem_wren,
    output logic [31:0] o_instr,
    output logic        o_pc_wren,
    output logic        o_pc_sel,
    output logic        o_rd_wren,
    output logic [1:0]  o_wb_sel,
    output logic [1:0]  o_opa_sel,
    output logic        o_opb_sel,
    output logic        o_br_un,
    output logic        o_jalr_mode,
    output logic [3:0]  o_alu_op,
    output logic        o_insn_vld,
    output logic        o_illegal,
    output logic        o_bus_err,
    output logic        o_halted
`ifdef MC_CTRL_RV32M_EN
    ,
    output logic        o_md_start,
    output logic [2:0]  o_md_op,
    input  logic        i_md_done
`endif
);

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_SLL  = 4'b0010;
    localparam logic [3:0] ALU_SLT  = 4'b0011;
    localparam logic [3:0] ALU_SLTU = 4'b0100;
    localparam logic [3:0] ALU_XOR  = 4'b0101;
    localparam logic [3:0] ALU_SRL  = 4'b0110;
    localparam logic [3:0] ALU_SRA  = 4'b0111;
    localparam logic [3:0] ALU_OR   = 4'b1000;
    localparam logic [3:0] ALU_AND  = 4'b1001;
    localparam logic [3:0] ALU_INV  = 4'b1111;

    // Counter only needs to reach TIMEOUT_CYC; a disabled timeout keeps a 1-bit stub.
    localparam int              CNT_W  = (TIMEOUT_CYC < 1) ? 1 : $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0] TO_LIM = CNT_W'(TIMEOUT_CYC);

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_HALT
    } state_t;

    state_t            r_state;
    logic [31:0]       r_ir;
    logic [CNT_W-1:0]  r_wait_cnt;

    // ------------------------------------------------------------------
    // Instruction field decode (one-hot opcode classes)
    // ------------------------------------------------------------------
    logic [6:0] w_opcode;
    logic [2:0] w_funct3;
    logic [6:0] w_funct7;
    logic [4:0] w_rd;
    logic       w_f7_alt;
    logic       w_is_lui, w_is_auipc, w_is_jal, w_is_jalr, w_is_br;
    logic       w_is_ld, w_is_st, w_is_opimm, w_is_alu_r, w_is_md;
    logic       w_legal;
    logic       w_br_taken;
    logic [3:0] w_alu_op;

    assign w_opcode = r_ir[6:0];
    assign w_funct3 = r_ir[14:12];
    assign w_funct7 = r_ir[31:25];
    assign w_rd     = r_ir[11:7];
    assign w_f7_alt = (w_funct7 == 7'b0100000);

    assign w_is_lui   = (w_opcode == OPC_LUI);
    assign w_is_auipc = (w_opcode == OPC_AUIPC);
    assign w_is_jal   = (w_opcode == OPC_JAL);
    assign w_is_jalr  = (w_opcode == OPC_JALR);
    assign w_is_br    = (w_opcode == OPC_BRANCH);
    assign w_is_ld    = (w_opcode == OPC_LOAD);
    assign w_is_st    = (w_opcode == OPC_STORE);
    assign w_is_opimm = (w_opcode == OPC_OPIMM);
    assign w_is_alu_r = (w_opcode == OPC_OP) && ((w_funct7 == 7'b0000000) || w_f7_alt);
`ifdef MC_CTRL_RV32M_EN
    assign w_is_md    = (w_opcode == OPC_OP) && (w_funct7 == 7'b0000001);
`else
    assign w_is_md    = 1'b0;
`endif

    assign w_legal = w_is_lui | w_is_auipc | w_is_jal | w_is_jalr | w_is_br |
                     w_is_ld | w_is_st | w_is_opimm | w_is_alu_r | w_is_md;

    always_comb begin
        w_alu_op = ALU_INV;
        if (w_is_alu_r || w_is_opimm) begin
            case (w_funct3)
                3'b000:  w_alu_op = (w_is_alu_r && w_f7_alt) ? ALU_SUB : ALU_ADD;
                3'b001:  w_alu_op = ALU_SLL;
                3'b010:  w_alu_op = ALU_SLT;
                3'b011:  w_alu_op = ALU_SLTU;
                3'b100:  w_alu_op = ALU_XOR;
                3'b101:  w_alu_op = w_f7_alt ? ALU_SRA : ALU_SRL;
                3'b110:  w_alu_op = ALU_OR;
                default: w_alu_op = ALU_AND;
            endcase
        end else if (w_legal) begin
            // Address/target/upper-immediate forms all use the adder; the
            // RV32M path does not consume the ALU result.
            w_alu_op = ALU_ADD;
        end
    end

    always_comb begin
        w_br_taken = 1'b0;
        case (w_funct3)
            3'b000:  w_br_taken = i_br_equal;
            3'b001:  w_br_taken = ~i_br_equal;
            3'b100:  w_br_taken = i_br_less;
            3'b101:  w_br_taken = ~i_br_less;
            3'b110:  w_br_taken = i_br_less;
            3'b111:  w_br_taken = ~i_br_less;
            default: w_br_taken = 1'b0;
        endcase
    end

    // Decode outputs follow the IR directly so they are stable from DECODE
    // until the retire cycle.
    assign o_instr     = r_ir;
    assign o_alu_op    = w_alu_op;
    assign o_wb_sel    = w_is_ld ? 2'b01 : ((w_is_jal || w_is_jalr) ? 2'b10 : 2'b00);
    assign o_opa_sel   = w_is_lui ? 2'b10 :
                         ((w_is_auipc || w_is_jal || w_is_br) ? 2'b01 : 2'b00);
    assign o_opb_sel   = w_is_lui | w_is_auipc | w_is_jal | w_is_jalr | w_is_br |
                         w_is_ld | w_is_st | w_is_opimm;
    // Comparator mode: 1 = signed (BEQ/BNE/BLT/BGE), 0 = unsigned (BLTU/BGEU).
    assign o_br_un     = w_is_br & ~w_funct3[1];
    assign o_jalr_mode = w_is_jalr;

    // ------------------------------------------------------------------
    // Bus wait / timeout
    // ------------------------------------------------------------------
    logic w_waiting;
    logic w_timeout;

    assign w_waiting = ((r_state == S_FETCH) && !i_imem_ack) ||
                       ((r_state == S_MEM)   && !i_dmem_ack);
    // An ack in the limit cycle clears w_waiting, so the ack wins.
    assign w_timeout = (TIMEOUT_CYC != 0) && w_waiting && (r_wait_cnt == TO_LIM);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wait_cnt <= '0;
        end else if (w_waiting && !w_timeout) begin
            // Saturate so a disabled timeout never wraps.
            if (r_wait_cnt != {CNT_W{1'b1}}) begin
                r_wait_cnt <= r_wait_cnt + CNT_W'(1);
            end
        end else begin
            r_wait_cnt <= '0;
        end
    end

    // ------------------------------------------------------------------
    // Sequencer
    // ------------------------------------------------------------------
`ifdef MC_CTRL_RV32M_EN
    logic r_md_busy;
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= S_FETCH;
            r_ir      <= '0;
`ifdef MC_CTRL_RV32M_EN
            r_md_busy <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_FETCH: begin
                    if (i_imem_ack) begin
                        r_ir    <= i_imem_rdata;
                        r_state <= S_DECODE;
                    end else if (w_timeout) begin
                        r_state <= S_HALT;
                    end
                end
                S_DECODE: begin
                    if (w_legal) begin
                        r_state <= S_EXEC;
                    end else if (ILLEGAL_HALT) begin
                        r_state <= S_HALT;
                    end else begin
                        r_state <= S_FETCH;
                    end
                end
                S_EXEC: begin
                    if (w_is_br) begin
                        r_state <= S_FETCH;
                    end else if (w_is_ld || w_is_st) begin
                        r_state <= S_MEM;
`ifdef MC_CTRL_RV32M_EN
                    end else if (w_is_md) begin
                        // First EXEC cycle issues the start pulse; done is only
                        // honoured once the operation is in flight.
                        if (!r_md_busy) begin
                            r_md_busy <= 1'b1;
                        end else if (i_md_done) begin
                            r_md_busy <= 1'b0;
                            r_state   <= S_WB;
                        end
`endif
                    end else begin
                        r_state <= S_WB;
                    end
                end
                S_MEM: begin
                    if (i_dmem_ack) begin
                        r_state <= w_is_st ? S_FETCH : S_WB;
                    end else if (w_timeout) begin
                        r_state <= S_HALT;
                    end
                end
                S_WB: begin
                    r_state <= S_FETCH;
                end
                default: begin
                    r_state <= S_HALT;
                end
            endcase
        end
    end

    // Strobes are decoded from the current state so an async reset removes
    // them immediately, and a store retires in its ack cycle.
    always_comb begin
        o_imem_req = 1'b0;
        o_dmem_req = 1'b0;
        o_mem_wren = 1'b0;
        o_pc_wren  = 1'b0;
        o_pc_sel   = 1'b0;
        o_rd_wren  = 1'b0;
        o_insn_vld = 1'b0;
        o_illegal  = 1'b0;
        o_bus_err  = 1'b0;
        o_halted   = 1'b0;
        case (r_state)
            S_FETCH: begin
                o_imem_req = 1'b1;
                o_bus_err  = w_timeout;
            end
            S_DECODE: begin
                o_illegal = ~w_legal;
                if (!w_legal && !ILLEGAL_HALT) begin
                    o_pc_wren  = 1'b1;
                    o_insn_vld = 1'b1;
                end
            end
            S_EXEC: begin
                if (w_is_br) begin
                    o_pc_wren  = 1'b1;
                    o_pc_sel   = w_br_taken;
                    o_insn_vld = 1'b1;
                end
            end
            S_MEM: begin
                o_dmem_req = 1'b1;
                o_mem_wren = w_is_st;
                o_bus_err  = w_timeout;
                if (i_dmem_ack && w_is_st) begin
                    o_pc_wren  = 1'b1;
                    o_insn_vld = 1'b1;
                end
            end
            S_WB: begin
                o_rd_wren  = (w_rd != 5'd0);
                o_pc_wren  = 1'b1;
                o_pc_sel   = w_is_jal | w_is_jalr;
                o_insn_vld = 1'b1;
            end
            default: begin
                o_halted = 1'b1;
            end
        endcase
    end

`ifdef MC_CTRL_RV32M_EN
    assign o_md_start = (r_state == S_EXEC) && w_is_md && !r_md_busy;
    assign o_md_op    = w_funct3;
`endif

endmodule

// File: tb/tb_mc_control_unit.sv
// Bench for mc_control_unit: random RV32I instruction stream with random memory latencies.
// Latency: each instruction checked cycle-by-cycle from FETCH entry to retire.
// Backpressure: ack delays and stale acks randomised; timeout and mid-wait reset exercised.
module tb_mc_control_unit;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    // Instruction kinds by the path they take through the unit.
    localparam int K_ILL = 0;
    localparam int K_BR  = 1;
    localparam int K_LD  = 2;
    localparam int K_ST  = 3;
    localparam int K_WB  = 4;
    localparam int K_MD  = 5;
`ifdef MC_CTRL_RV32M_EN
    localparam int K_F7_ONE = K_MD;
`else
    localparam int K_F7_ONE = K_ILL;
`endif

    typedef struct packed {
        logic imem_req;
        logic dmem_req;
        logic mem_wren;
        logic pc_wren;
        logic pc_sel;
        logic rd_wren;
        logic insn_vld;
        logic illegal;
        logic bus_err;
        logic halted;
    } strb_t;

    typedef struct packed {
        logic [31:0] instr;
        logic [1:0]  wb_sel;
        logic [1:0]  opa_sel;
        logic        opb_sel;
        logic        br_un;
        logic        jalr_mode;
        logic [3:0]  alu_op;
    } dec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        imem_ack = 1'b0;
    logic        dmem_ack = 1'b0;
    logic        br_less = 1'b0;
    logic        br_equal = 1'b0;

    logic        a_imem_req, a_dmem_req, a_mem_wren, a_pc_wren, a_pc_sel, a_rd_wren;
    logic        a_opb_sel, a_br_un, a_jalr_mode, a_insn_vld, a_illegal, a_bus_err, a_halted;
    logic [31:0] a_instr;
    logic [1:0]  a_wb_sel, a_opa_sel;
    logic [3:0]  a_alu_op;
    logic        b_imem_req, b_dmem_req, b_mem_wren, b_pc_wren, b_pc_sel, b_rd_wren;
    logic        b_opb_sel, b_br_un, b_jalr_mode, b_insn_vld, b_illegal, b_bus_err, b_halted;
    logic [31:0] b_instr;
    logic [1:0]  b_wb_sel, b_opa_sel;
    logic [3:0]  b_alu_op;
`ifdef MC_CTRL_RV32M_EN
    logic        md_done = 1'b0;
    logic        a_md_start, b_md_start;
    logic [2:0]  a_md_op, b_md_op;
`endif

    strb_t sa, sb;
    dec_t  da, db;
    assign sa = {a_imem_req, a_dmem_req, a_mem_wren, a_pc_wren, a_pc_sel, a_rd_wren,
                 a_insn_vld, a_illegal, a_bus_err, a_halted};
    assign sb = {b_imem_req, b_dmem_req, b_mem_wren, b_pc_wren, b_pc_sel, b_rd_wren,
                 b_insn_vld, b_illegal, b_bus_err, b_halted};
    assign da = {a_instr, a_wb_sel, a_opa_sel, a_opb_sel, a_br_un, a_jalr_mode, a_alu_op};
    assign db = {b_instr, b_wb_sel, b_opa_sel, b_opb_sel, b_br_un, b_jalr_mode, b_alu_op};

    always #5 clk = ~clk;

    // Unit A: short timeout, halts on illegal. Unit B: no timeout, illegal retires as NOP.
    mc_control_unit #(.TIMEOUT_CYC(4), .ILLEGAL_HALT(1'b1)) u_dut_a (
        .i_clk(clk), .i_rst_n(rst_n), .i_imem_rdata(imem_rdata), .i_imem_ack(imem_ack),
        .i_dmem_ack(dmem_ack), .i_br_less(br_less), .i_br_equal(br_equal),
        .o_imem_req(a_imem_req), .o_dmem_req(a_dmem_req), .o_mem_wren(a_mem_wren),
        .o_instr(a_instr), .o_pc_wren(a_pc_wren), .o_pc_sel(a_pc_sel), .o_rd_wren(a_rd_wren),
        .o_wb_sel(a_wb_sel), .o_opa_sel(a_opa_sel), .o_opb_sel(a_opb_sel), .o_br_un(a_br_un),
        .o_jalr_mode(a_jalr_mode), .o_alu_op(a_alu_op), .o_insn_vld(a_insn_vld),
        .o_illegal(a_illegal), .o_bus_err(a_bus_err), .o_halted(a_halted)
`ifdef MC_CTRL_RV32M_EN
        , .o_md_start(a_md_start), .o_md_op(a_md_op), .i_md_done(md_done)
`endif
    );

    mc_control_unit #(.TIMEOUT_CYC(0), .ILLEGAL_HALT(1'b0)) u_dut_b (
        .i_clk(clk), .i_rst_n(rst_n), .i_imem_rdata(imem_rdata), .i_imem_ack(imem_ack),
        .i_dmem_ack(dmem_ack), .i_br_less(br_less), .i_br_equal(br_equal),
        .o_imem_req(b_imem_req), .o_dmem_req(b_dmem_req), .o_mem_wren(b_mem_wren),
        .o_instr(b_instr), .o_pc_wren(b_pc_wren), .o_pc_sel(b_pc_sel), .o_rd_wren(b_rd_wren),
        .o_wb_sel(b_wb_sel), .o_opa_sel(b_opa_sel), .o_opb_sel(b_opb_sel), .o_br_un(b_br_un),
        .o_jalr_mode(b_jalr_mode), .o_alu_op(b_alu_op), .o_insn_vld(b_insn_vld),
        .o_illegal(b_illegal), .o_bus_err(b_bus_err), .o_halted(b_halted)
`ifdef MC_CTRL_RV32M_EN
        , .o_md_start(b_md_start), .o_md_op(b_md_op), .i_md_done(md_done)
`endif
    );

    int          n_chk = 0;
    int          n_pass = 0;
    logic [31:0] cur_ir = '0;
    dec_t        cur_dec;
    logic        exp_md_start = 1'b0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    endtask

    // ---------------- reference model ----------------
    function automatic int kind_of(input logic [31:0] ir);
        case (ir[6:0])
            OPC_BRANCH: return K_BR;
            OPC_LOAD:   return K_LD;
            OPC_STORE:  return K_ST;
            OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_OPIMM: return K_WB;
            OPC_OP: begin
                if (ir[31:25] == 7'h00 || ir[31:25] == 7'h20) return K_WB;
                if (ir[31:25] == 7'h01) return K_F7_ONE;
                return K_ILL;
            end
            default: return K_ILL;
        endcase
    endfunction

    // ALU code for a register/immediate arithmetic op given funct3 and alternate-form flags.
    function automatic logic [3:0] alu_of(input logic [2:0] f3, input logic sub_ok,
                                          input logic sra_ok);
        case (f3)
            3'd0:    return sub_ok ? 4'd1 : 4'd0;
            3'd1:    return 4'd2;
            3'd2:    return 4'd3;
            3'd3:    return 4'd4;
            3'd4:    return 4'd5;
            3'd5:    return sra_ok ? 4'd7 : 4'd6;
            3'd6:    return 4'd8;
            default: return 4'd9;
        endcase
    endfunction

    function automatic dec_t ref_dec(input logic [31:0] ir);
        dec_t       d;
        logic [2:0] f3;
        logic       alt;
        d = '0;
        d.instr = ir;
        d.alu_op = 4'hF;
        f3 = ir[14:12];
        alt = (ir[31:25] == 7'h20);
        if (kind_of(ir) == K_ILL) return d;
        d.alu_op = 4'h0;
        case (ir[6:0])
            OPC_LUI:    begin d.opa_sel = 2'b10; d.opb_sel = 1'b1; end
            OPC_AUIPC:  begin d.opa_sel = 2'b01; d.opb_sel = 1'b1; end
            OPC_JAL:    begin d.opa_sel = 2'b01; d.opb_sel = 1'b1; d.wb_sel = 2'b10; end
            OPC_JALR:   begin d.opb_sel = 1'b1; d.wb_sel = 2'b10; d.jalr_mode = 1'b1; end
            OPC_BRANCH: begin
                d.opa_sel = 2'b01; d.opb_sel = 1'b1;
                d.br_un = (f3 inside {3'd0, 3'd1, 3'd4, 3'd5});
            end
            OPC_LOAD:   begin d.opb_sel = 1'b1; d.wb_sel = 2'b01; end
            OPC_STORE:  d.opb_sel = 1'b1;
            OPC_OPIMM:  begin d.opb_sel = 1'b1; d.alu_op = alu_of(f3, 1'b0, alt); end
            OPC_OP:     if (kind_of(ir) == K_WB) d.alu_op = alu_of(f3, alt, alt);
            default: ;
        endcase
        return d;
    endfunction

    function automatic logic br_taken(input logic [2:0] f3, input logic eq, input logic lt);
        case (f3)
            3'd0: return eq;
            3'd1: return !eq;
            3'd4: return lt;
            3'd5: return !lt;
            3'd6: return lt;
            3'd7: return !lt;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] gen_ir();
        logic [31:0] r;
        logic        coin;
        r = $urandom;
        coin = r[30];
        case ($urandom_range(0, 11))
            0:  r[6:0] = OPC_LUI;
            1:  r[6:0] = OPC_AUIPC;
            2:  r[6:0] = OPC_JAL;
            3:  r[6:0] = OPC_JALR;
            4:  r[6:0] = OPC_BRANCH;
            5:  r[6:0] = OPC_LOAD;
            6:  r[6:0] = OPC_STORE;
            7: begin
                r[6:0] = OPC_OPIMM;
                if (r[14:12] == 3'd1) r[31:25] = 7'h00;
                else if (r[14:12] == 3'd5) r[31:25] = coin ? 7'h20 : 7'h00;
            end
            8: begin
                r[6:0] = OPC_OP;
                r[31:25] = (coin && (r[14:12] == 3'd0 || r[14:12] == 3'd5)) ? 7'h20 : 7'h00;
            end
            9: begin r[6:0] = OPC_OP; r[31:25] = 7'h01; end
            10: begin
                do r[6:0] = 7'($urandom); while (kind_of(r) != K_ILL);
            end
            default: r = '0;
        endcase
        return r;
    endfunction

    // ---------------- stimulus helpers ----------------
    // One clock cycle: drive acks, sample both units at the falling edge.
    task automatic cyc(input logic ia, input logic dack_in, input logic fetching,
                       input strb_t ea, input strb_t eb, input logic dchk);
        imem_ack = ia;
        dmem_ack = dack_in;
        imem_rdata = (ia && fetching) ? cur_ir : $urandom;
        @(negedge clk);
        check("strobes_a", 64'(sa), 64'(ea));
        check("strobes_b", 64'(sb), 64'(eb));
        if (dchk) begin
            check("decode_a", 64'(da), 64'(cur_dec));
            check("decode_b", 64'(db), 64'(cur_dec));
        end
`ifdef MC_CTRL_RV32M_EN
        check("md_start_a", 64'(a_md_start), 64'(exp_md_start));
        check("md_start_b", 64'(b_md_start), 64'(exp_md_start));
`endif
        @(posedge clk);
        #1;
        imem_ack = 1'b0;
        dmem_ack = 1'b0;
    endtask

    task automatic chk_reset();
        strb_t e;
        e = '0;
        e.imem_req = 1'b1;
        check("reset_strobes_a", 64'(sa), 64'(e));
        check("reset_strobes_b", 64'(sb), 64'(e));
        check("reset_decode_a", 64'(da), 64'(ref_dec(32'h0)));
        check("reset_decode_b", 64'(db), 64'(ref_dec(32'h0)));
`ifdef MC_CTRL_RV32M_EN
        check("reset_md_start_a", 64'(a_md_start), 64'd0);
`endif
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        imem_ack = 1'b0;
        dmem_ack = 1'b0;
        #1;
        chk_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Runs one instruction from FETCH entry through retire; di/dd/dm are ack delays.
    task automatic run_insn(input logic [31:0] ir, input int di, input int dd, input int dm,
                            input logic eq, input logic lt);
        strb_t e, eb;
        int    k;
        k = kind_of(ir);
        cur_ir = ir;
        cur_dec = ref_dec(ir);
        br_equal = eq;
        br_less = lt;
        for (int c = 0; c <= di; c++) begin
            e = '0;
            e.imem_req = 1'b1;
            cyc(c == di, 1'($urandom_range(0, 1)), 1'b1, e, e, 1'b0);
        end
        // DECODE
        e = '0;
        eb = '0;
        if (k == K_ILL) begin
            e.illegal = 1'b1;
            eb.illegal = 1'b1;
            eb.pc_wren = 1'b1;
            eb.insn_vld = 1'b1;
        end
        cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0, e, eb, 1'b1);
        if (k == K_ILL) begin
            for (int c = 0; c < 3; c++) begin
                e = '0;
                e.halted = 1'b1;
                eb = '0;
                eb.imem_req = 1'b1;
                cyc(1'b0, 1'b0, 1'b0, e, eb, 1'b1);
            end
            do_reset();
            return;
        end
        // EXEC
        e = '0;
        if (k == K_BR) begin
            e.pc_wren = 1'b1;
            e.pc_sel = br_taken(ir[14:12], eq, lt);
            e.insn_vld = 1'b1;
            cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0, e, e, 1'b1);
            return;
        end
`ifdef MC_CTRL_RV32M_EN
        if (k == K_MD) begin
            for (int c = 0; c <= dm; c++) begin
                exp_md_start = (c == 0);
                md_done = (c == dm);
                if (c == 0) begin
                    check("md_op_a", 64'(a_md_op), 64'(ir[14:12]));
                    check("md_op_b", 64'(b_md_op), 64'(ir[14:12]));
                end
                cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0, e, e, 1'b1);
            end
            exp_md_start = 1'b0;
            md_done = 1'b0;
        end else
`endif
        cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0, e, e, 1'b1);
        if (k == K_LD || k == K_ST) begin
            for (int c = 0; c <= dd; c++) begin
                e = '0;
                e.dmem_req = 1'b1;
                e.mem_wren = (k == K_ST);
                if (c == dd && k == K_ST) begin
                    e.pc_wren = 1'b1;
                    e.insn_vld = 1'b1;
                end
                cyc(1'($urandom_range(0, 1)), c == dd, 1'b0, e, e, 1'b1);
            end
            if (k == K_ST) return;
        end
        // WB
        e = '0;
        e.pc_wren = 1'b1;
        e.pc_sel = (ir[6:0] == OPC_JAL) || (ir[6:0] == OPC_JALR);
        e.rd_wren = (ir[11:7] != 5'd0);
        e.insn_vld = 1'b1;
        cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0, e, e, 1'b1);
    endtask

    task automatic run_timeout();
        strb_t ea, eb;
        for (int c = 0; c <= 6; c++) begin
            ea = '0;
            eb = '0;
            eb.imem_req = 1'b1;
            if (c <= 4) ea.imem_req = 1'b1;
            if (c == 4) ea.bus_err = 1'b1;
            if (c > 4)  ea.halted = 1'b1;
            cyc(1'b0, 1'b0, 1'b1, ea, eb, 1'b0);
        end
        do_reset();
    endtask

    task automatic run_reset_mid_wait();
        strb_t e;
        cur_ir = 32'h0000A283;   // LW x5,0(x1)
        cur_dec = ref_dec(cur_ir);
        e = '0;
        e.imem_req = 1'b1;
        cyc(1'b1, 1'b0, 1'b1, e, e, 1'b0);
        e = '0;
        cyc(1'b0, 1'b0, 1'b0, e, e, 1'b1);
        cyc(1'b0, 1'b0, 1'b0, e, e, 1'b1);
        e.dmem_req = 1'b1;
        cyc(1'b0, 1'b0, 1'b0, e, e, 1'b1);
        cyc(1'b0, 1'b0, 1'b0, e, e, 1'b1);
        #2;
        do_reset();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        @(posedge clk);
        #1;
        do_reset();
        run_insn(32'h00500093, 0, 0, 1, 1'b0, 1'b0);   // ADDI x1,x0,5
        run_insn(32'h00209463, 0, 0, 1, 1'b0, 1'b0);   // BNE taken
        run_insn(32'h00209463, 0, 0, 1, 1'b1, 1'b0);   // BNE not taken
        run_insn(32'h0000A283, 0, 3, 1, 1'b0, 1'b0);   // LW, data ack after 3 waits
        run_insn(32'h00500093, 4, 0, 1, 1'b0, 1'b0);   // fetch ack at the timeout limit
        run_insn(32'h0020A223, 1, 4, 1, 1'b0, 1'b0);   // SW, data ack at the limit
        run_insn(32'h00000000, 0, 0, 1, 1'b0, 1'b0);   // all-zero instruction
`ifdef MC_CTRL_RV32M_EN
        run_insn(32'h022081B3, 0, 0, 6, 1'b0, 1'b0);   // MUL x3,x1,x2
`endif
        run_timeout();
        run_reset_mid_wait();
        for (int n = 0; n < 80; n++) begin
            run_insn(gen_ir(), $urandom_range(0, 4), $urandom_range(0, 4),
                     $urandom_range(1, 5), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
